// File: rtl/dmem_responder.sv
// Single-port data memory slave with req/rsp handshakes, configurable wait states and byte/half/word access.
// Optional misalignment faulting is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wren,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_num_byte,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // ACCESS is the single cycle that presents the address; the RAM is touched on the edge leaving it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;

  logic        r_wren;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_num_byte;

  logic        w_accept;
  logic        w_do_access;
  logic        w_oor;
  logic        w_misalign;
  logic        w_err;
  logic [AW-1:0]    w_index;
  logic [3:0]       w_be;
  logic [3:0][7:0]  w_wlane;
  logic [3:0][7:0]  w_rd_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_rdata;

  assign w_accept    = (r_state == IDLE) && i_req_valid && !i_rst;
  assign w_do_access = (r_state == ACCESS) && !i_rst;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_cnt_next   = WAIT_LOAD;
          w_state_next = NO_WAIT ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ACCESS;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ACCESS: w_state_next = RESP;
      RESP: begin
        if (i_rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request fields are frozen at accept so later input wiggles cannot disturb the access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wren     <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_num_byte <= 3'd0;
    end else if (w_accept) begin
      r_wren     <= i_req_wren;
      r_addr     <= i_req_addr;
      r_wdata    <= i_req_wdata;
      r_num_byte <= i_req_num_byte;
    end
  end

  generate
    if (AW + 2 < 32) begin : g_oor
      assign w_oor = |r_addr[31:AW+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = ((r_num_byte[1:0] == 2'b01) && r_addr[0]) ||
                      (r_num_byte[1] && (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err   = w_oor | w_misalign;
  assign w_index = r_addr[AW+1:2];

  // Size code 11 falls into the word branch.
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = r_wdata;
    case (r_num_byte[1:0])
      2'b00: begin
        w_be[r_addr[1:0]] = 1'b1;
        w_wlane           = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be[{r_addr[1], 1'b0}] = 1'b1;
        w_be[{r_addr[1], 1'b1}] = 1'b1;
        w_wlane                 = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rd_lane;

      always_ff @(posedge i_clk) begin
        if (w_do_access) begin
          if (r_wren && !w_err && w_be[gi]) begin
            r_mem[w_index] <= w_wlane[gi];
          end
          r_rd_lane <= r_mem[w_index];
        end
      end

      assign w_rd_word[gi] = r_rd_lane;
    end
  endgenerate

  always_comb begin
    w_rdata = 32'd0;
    w_byte  = w_rd_word[r_addr[1:0]];
    w_half  = {w_rd_word[{r_addr[1], 1'b1}], w_rd_word[{r_addr[1], 1'b0}]};
    if (!r_wren && !w_err) begin
      case (r_num_byte[1:0])
        2'b00:   w_rdata = r_num_byte[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        2'b01:   w_rdata = r_num_byte[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        default: w_rdata = w_rd_word;
      endcase
    end
  end

  assign o_req_ready = (r_state == IDLE) && !i_rst;
  assign o_rsp_valid = (r_state == RESP) && !i_rst;
  assign o_rsp_rdata = o_rsp_valid ? w_rdata : 32'd0;
  assign o_rsp_err   = o_rsp_valid & w_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;
  localparam int LAT   = WAITC + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wren = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_nb = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_mem [0:4*DEPTH-1];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_wren(req_wren),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .i_req_num_byte(req_nb),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: memory as a flat byte array, accesses as byte counts with arithmetic extension.
  function automatic void model_apply(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [2:0] nb, output logic [31:0] rdata, output logic err);
    int n;
    int base;
    logic [31:0] v;
    n = (nb[1:0] == 2'b00) ? 1 : (nb[1:0] == 2'b01) ? 2 : 4;
    err = (addr >= 32'(4 * DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((addr % 32'(n)) != 32'd0) err = 1'b1;
`endif
    rdata = 32'd0;
    if (err) return;
    base = int'(addr - (addr % 32'(n)));
    if (wren) begin
      for (int k = 0; k < n; k++) model_mem[base + k] = wdata[8*k +: 8];
      return;
    end
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(model_mem[base + k]) << (8 * k));
    if (n < 4 && !nb[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    rdata = v;
  endfunction

  task automatic scramble();
    req_wren  = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_nb    = 3'($urandom);
  endtask

  // Drives one transaction starting just after a falling edge; returns observations only.
  task automatic run_txn(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] nb, input int hold, output int lat, output logic [31:0] rdata,
                         output logic err, output logic proto_ok, output logic idle_after);
    req_valid = 1'b1; req_wren = wren; req_addr = addr; req_wdata = wdata; req_nb = nb;
    rsp_ready = 1'b0;
    proto_ok = (req_ready === 1'b1);
    lat = 0; rdata = 32'd0; err = 1'b0; idle_after = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      scramble();
      req_valid = 1'($urandom);
      if (rsp_valid === 1'b1) break;
      if (req_ready !== 1'b0) proto_ok = 1'b0;
      if (lat > 40) begin
        lat = -1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (lat < 0) begin
      req_valid = 1'b0;
      return;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (req_ready !== 1'b0) proto_ok = 1'b0;
    req_valid = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      scramble();
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0) proto_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    idle_after = (req_ready === 1'b1 && rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b expected 0 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_prefill();
    int lat; logic [31:0] rd, exp_rd, d; logic er, exp_er, pok, idl;
    for (int w = 0; w < 128; w++) begin
      d = $urandom;
      model_apply(1'b1, 32'(w * 4), d, 3'b010, exp_rd, exp_er);
      run_txn(1'b1, 32'(w * 4), d, 3'b010, 0, lat, rd, er, pok, idl);
      checks++;
      if (lat !== LAT || er !== 1'b0 || rd !== 32'd0 || !idl) begin
        failures++;
        $display("FAIL prefill[%0d]: got lat=%0d err=%b rdata=%h idle=%b expected lat=%0d err=0 rdata=0 idle=1",
                 w, lat, er, rd, idl, LAT);
      end
    end
  endtask

  task automatic test_word_and_byte();
    int lat; logic [31:0] rd, mr; logic er, me, pok, idl;
    model_apply(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, mr, me);
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, lat, rd, er, pok, idl);
    checks++;
    if (lat !== LAT || rd !== 32'd0 || er !== 1'b0) begin
      failures++;
      $display("FAIL store_word: got lat=%0d rdata=%h err=%b expected lat=%0d rdata=0 err=0", lat, rd, er, LAT);
    end
    model_apply(1'b0, 32'h10, 32'd0, 3'b010, mr, me);
    run_txn(1'b0, 32'h10, 32'h0, 3'b010, 0, lat, rd, er, pok, idl);
    checks++;
    if (lat !== LAT || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL load_word: got lat=%0d rdata=%h err=%b expected lat=%0d rdata=deadbeef err=0", lat, rd, er, LAT);
    end
    model_apply(1'b1, 32'h10, 32'h0, 3'b010, mr, me);
    run_txn(1'b1, 32'h10, 32'h0, 3'b010, 0, lat, rd, er, pok, idl);
    model_apply(1'b1, 32'h13, 32'h0000_0080, 3'b000, mr, me);
    run_txn(1'b1, 32'h13, 32'h1234_5680, 3'b000, 1, lat, rd, er, pok, idl);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || !pok) begin
      failures++;
      $display("FAIL store_byte: got rdata=%h err=%b proto=%b expected rdata=0 err=0 proto=1", rd, er, pok);
    end
    run_txn(1'b0, 32'h13, 32'h0, 3'b000, 0, lat, rd, er, pok, idl);
    checks++;
    if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin
      failures++;
      $display("FAIL load_byte_signed: got %h err=%b expected ffffff80 err=0", rd, er);
    end
    run_txn(1'b0, 32'h13, 32'h0, 3'b100, 0, lat, rd, er, pok, idl);
    checks++;
    if (rd !== 32'h0000_0080 || er !== 1'b0) begin
      failures++;
      $display("FAIL load_byte_unsigned: got %h err=%b expected 00000080 err=0", rd, er);
    end
    run_txn(1'b0, 32'h10, 32'h0, 3'b110, 0, lat, rd, er, pok, idl);
    checks++;
    if (rd !== 32'h8000_0000 || er !== 1'b0) begin
      failures++;
      $display("FAIL load_word_after_byte: got %h err=%b expected 80000000 err=0", rd, er);
    end
  endtask

  task automatic test_stall();
    int lat; logic [31:0] rd, mr; logic er, me, pok, idl;
    model_apply(1'b0, 32'h44, 32'd0, 3'b010, mr, me);
    run_txn(1'b0, 32'h44, 32'h0, 3'b010, 5, lat, rd, er, pok, idl);
    checks++;
    if (!pok || !idl) begin
      failures++;
      $display("FAIL stall_protocol: got stable=%b idle_after=%b expected 1 1", pok, idl);
    end
    checks++;
    if (rd !== mr || er !== me) begin
      failures++;
      $display("FAIL stall_data: got %h err=%b expected %h err=%b", rd, er, mr, me);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, mr, a; logic er, me, pok, idl;
    model_apply(1'b1, 32'(4 * DEPTH), 32'hCAFE_F00D, 3'b010, mr, me);
    run_txn(1'b1, 32'(4 * DEPTH), 32'hCAFE_F00D, 3'b010, 0, lat, rd, er, pok, idl);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== LAT) begin
      failures++;
      $display("FAIL oor_store: got err=%b rdata=%h lat=%0d expected err=1 rdata=0 lat=%0d", er, rd, lat, LAT);
    end
    a = 32'(4 * DEPTH) + ($urandom & 32'h7FFF_0000);
    run_txn(1'b0, a, 32'h0, 3'b001, 0, lat, rd, er, pok, idl);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL oor_load: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
    end
    model_apply(1'b0, 32'h0, 32'd0, 3'b010, mr, me);
    run_txn(1'b0, 32'h0, 32'h0, 3'b010, 0, lat, rd, er, pok, idl);
    checks++;
    if (rd !== mr || er !== 1'b0) begin
      failures++;
      $display("FAIL oor_word0_unchanged: got %h err=%b expected %h err=0", rd, er, mr);
    end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd, mr; logic er, me, pok, idl, exp_err;
`ifdef DMEM_MISALIGN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    model_apply(1'b1, 32'h21, 32'h0000_A5C3, 3'b001, mr, me);
    run_txn(1'b1, 32'h21, 32'h0000_A5C3, 3'b001, 0, lat, rd, er, pok, idl);
    checks++;
    if (er !== exp_err || rd !== 32'd0) begin
      failures++;
      $display("FAIL misalign_half_store: got err=%b rdata=%h expected err=%b rdata=0", er, rd, exp_err);
    end
    model_apply(1'b0, 32'h20, 32'd0, 3'b010, mr, me);
    run_txn(1'b0, 32'h20, 32'h0, 3'b010, 0, lat, rd, er, pok, idl);
    checks++;
    if (rd !== mr || er !== me) begin
      failures++;
      $display("FAIL misalign_word20: got %h err=%b expected %h err=%b", rd, er, mr, me);
    end
  endtask

  task automatic test_random();
    int lat, hold; logic [31:0] rd, mr, a, d; logic er, me, pok, idl, w; logic [2:0] nb;
    for (int i = 0; i < 300; i++) begin
      w    = 1'($urandom);
      a    = ($urandom_range(0, 9) == 0) ? (32'(4 * DEPTH) + ($urandom & 32'h0FFF_FFFF)) : 32'($urandom_range(0, 511));
      d    = $urandom;
      nb   = 3'($urandom);
      hold = $urandom_range(0, 3);
      model_apply(w, a, d, nb, mr, me);
      run_txn(w, a, d, nb, hold, lat, rd, er, pok, idl);
      checks++;
      if (rd !== mr || er !== me) begin
        failures++;
        $display("FAIL rand_data[%0d]: wr=%b addr=%h nb=%b got %h err=%b expected %h err=%b",
                 i, w, a, nb, rd, er, mr, me);
      end
      checks++;
      if (lat !== LAT || !pok || !idl) begin
        failures++;
        $display("FAIL rand_proto[%0d]: got lat=%0d stable=%b idle=%b expected lat=%0d 1 1", i, lat, pok, idl, LAT);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd, prior, d; logic er, me, pok, idl, seen;
    for (int d_extra = 0; d_extra <= 2; d_extra += 2) begin
      model_apply(1'b0, 32'h40, 32'd0, 3'b010, prior, me);
      d = ~prior;
      req_valid = 1'b1; req_wren = 1'b1; req_addr = 32'h40; req_wdata = d; req_nb = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (d_extra) begin
        @(posedge clk);
        @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL midwait_reset_outputs[%0d]: got ready=%b valid=%b rdata=%h err=%b expected 0 0 0 0",
                 d_extra, req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin
        @(posedge clk);
        @(negedge clk);
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        failures++;
        $display("FAIL midwait_after_release[%0d]: got stray response or ready low, expected idle", d_extra);
      end
      run_txn(1'b0, 32'h40, 32'h0, 3'b010, 0, lat, rd, er, pok, idl);
      checks++;
      if (rd !== prior || er !== 1'b0) begin
        failures++;
        $display("FAIL midwait_word40[%0d]: got %h err=%b expected %h err=0", d_extra, rd, er, prior);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_word_and_byte();
    test_stall();
    test_out_of_range();
    test_misalign();
    test_random();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait states between request accept and response (range 0..15).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port o_req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port i_req_wren, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port i_req_addr, input, 32 bits: the byte address.
REQ-009 The block SHALL have port i_req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port i_req_num_byte, input, 3 bits: [1:0] size (00 byte, 01 half, 10 word, 11 reserved, treated as word); [2] = 1 means an unsigned load.
REQ-011 The block SHALL have port o_rsp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port i_rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 The block SHALL have port o_rsp_rdata, output, 32 bits: load data, extended to 32 bits; 0 for stores.
REQ-014 The block SHALL have port o_rsp_err, output, 1 bit: the access faulted.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 IDLE: o_req_ready=1 and o_rsp_valid=0.
REQ-017 IDLE: when i_req_valid=1, the block SHALL capture wren, addr, wdata and num_byte, and go to WAIT (WAIT_CYCLES>0) or ACCESS-to-RESP (WAIT_CYCLES=0).
REQ-018 WAIT: o_req_ready=0. The counter SHALL load WAIT_CYCLES-1 on accept and decrement each cycle. When it reaches 0, the block SHALL perform the access and go to RESP.
REQ-019 The access SHALL happen on the edge that enters RESP. The response SHALL first be visible WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 RESP: o_rsp_valid=1, o_req_ready=0. rdata and err SHALL stay stable until i_rsp_ready=1, then the block SHALL return to IDLE. There is no back-to-back accept in the handshake cycle.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; byte lane SHALL be addr[1:0].
REQ-022 Byte store SHALL write lane addr[1:0] with wdata[7:0]. Half store SHALL write lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. Word store SHALL write all lanes. Other lanes SHALL be unchanged.
REQ-023 Loads SHALL extract the selected lane(s) and sign-extend them, or zero-extend them when num_byte[2]=1. Word loads SHALL ignore num_byte[2].
REQ-024 Out of range (addr >= 4*DEPTH_WORDS) SHALL give err=1, rdata=0, and no write.
REQ-025 A store response SHALL return rdata=0 and err=0 unless REQ-024 or REQ-029 applies.
REQ-026 Changes on request inputs while not in IDLE SHALL be ignored; the captured copy is used.

Reset
REQ-027 While i_rst=1: state=IDLE, counter=0, o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. o_req_ready SHALL rise the first cycle after i_rst falls.
REQ-028 Reset mid-WAIT or mid-RESP SHALL drop the transaction: no write occurs if not yet performed, no response is produced, and storage contents are retained (not cleared).

Configuration
REQ-029 With macro DMEM_MISALIGN_CHECK_EN defined, a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL give err=1, rdata=0, and no write. Without the macro, the misaligned low address bits SHALL be ignored (forced to alignment) and err SHALL be driven only by REQ-024.

Verification
REQ-030 Reset then store word addr 0x10 data 0xDEADBEEF, then load word 0x10 (WAIT_CYCLES=2) -> rsp_valid 3 cycles after each accept; rdata 0xDEADBEEF, err 0.
REQ-031 Store byte 0x80 to 0x13 over 0x00000000, then signed byte load 0x13 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load 0x10 -> 0x80000000.
REQ-032 Load with i_rsp_ready held 0 for 5 cycles -> rsp_valid, rdata and err stable for 5 cycles; req_ready=0 throughout; IDLE one cycle after ready=1.
REQ-033 Store word to 4*DEPTH_WORDS -> err 1, rdata 0; a subsequent load of word 0 is unchanged.
REQ-034 Half store to 0x21 -> with DMEM_MISALIGN_CHECK_EN: err 1, memory unchanged; without it: err 0, lanes 0x20-0x21 written.
REQ-035 Assert i_rst during WAIT of a store to 0x40 -> no response; word 0x40 holds its prior value; req_ready=1 the cycle after reset is released.
